// File: rtl/guvm_icache_responder_pkg.sv
// Shared types and constants for the GUVM icache responder: FSM states,
// the reset/idle instruction word and the FIFO entry layout.
package guvm_resp_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        STARVE
    } resp_state_e;

    typedef struct packed {
        logic              exc;
        logic [INST_W-1:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/guvm_icache_responder_if.sv
// Bus between the UVM side (driver/core model/monitor) and the responder:
// instruction push channel, core fetch port and completed-fetch log.
interface guvm_icache_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WAIT_W = 4
);
    logic [WAIT_W-1:0] wait_states;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_inst;
    logic              push_exc;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic [DATA_W-1:0] ico_data;
    logic              ico_hold;
    logic              ico_exception;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_inst;

    modport master (
        output wait_states, push_valid, push_inst, push_exc,
        output fetch_req, fetch_addr, fetch_flush,
        input  push_ready, ico_data, ico_hold, ico_exception,
        input  log_valid, log_addr, log_inst
    );

    modport slave (
        input  wait_states, push_valid, push_inst, push_exc,
        input  fetch_req, fetch_addr, fetch_flush,
        output push_ready, ico_data, ico_hold, ico_exception,
        output log_valid, log_addr, log_inst
    );

endinterface

// File: rtl/guvm_icache_responder_fifo.sv
// Synchronous FIFO of instruction entries; DEPTH must be a power of two so
// the pointers wrap naturally.
module guvm_inst_fifo
    import guvm_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  inst_entry_t                  push_data_i,
    input  logic                         pop_i,
    output inst_entry_t                  pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    inst_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/guvm_icache_responder.sv
// Icache responder: answers core fetches from the driver-fed FIFO after a
// programmable wait, stalling the core until the registered delivery cycle.
module guvm_icache_responder
    import guvm_resp_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = INST_W,
    parameter int ADDR_W = 32,
    parameter int WAIT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    guvm_icache_responder_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    resp_state_e        state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               push_ready_q, push_ready_d;
    logic [DATA_W-1:0]  ico_data_q;
    logic               ico_exc_q, ico_hold_q;
    logic               log_valid_q;
    logic [ADDR_W-1:0]  log_addr_q;
    logic [DATA_W-1:0]  log_inst_q;

    logic               push_fire, pop_fire;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, cnt_next;
    inst_entry_t        push_entry, head;

    assign push_fire  = bus.push_valid && push_ready_q && !fifo_full;
    assign push_entry = '{exc: bus.push_exc, inst: bus.push_inst};

    guvm_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_fire),
        .push_data_i (push_entry),
        .pop_i       (pop_fire),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // push_ready is registered, so it looks ahead at the post-edge occupancy.
    assign cnt_next     = fifo_count + CNT_W'(push_fire) - CNT_W'(pop_fire);
    assign push_ready_d = (cnt_next != CNT_W'(DEPTH));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        pop_fire = 1'b0;
        if (state_q != IDLE && bus.fetch_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.fetch_req) begin
                    addr_d  = bus.fetch_addr;
                    cnt_d   = bus.wait_states;
                    state_d = (bus.wait_states == '0) ? RESP : WAIT;
                end
                WAIT: if (cnt_q <= WAIT_W'(1)) state_d = RESP;
                      else cnt_d = cnt_q - WAIT_W'(1);
                RESP: if (!fifo_empty) begin
                    pop_fire = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = STARVE;
                end
                // A push seen here lands in the FIFO by the time RESP pops.
                STARVE: if (!fifo_empty || push_fire) state_d = RESP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            push_ready_q <= 1'b0;
            ico_data_q   <= NOP_INST;
            ico_exc_q    <= 1'b0;
            ico_hold_q   <= 1'b1;
            log_valid_q  <= 1'b0;
            log_addr_q   <= '0;
            log_inst_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            push_ready_q <= push_ready_d;
            ico_hold_q   <= !pop_fire;
            log_valid_q  <= pop_fire;
            if (pop_fire) begin
                ico_data_q <= head.inst;
                ico_exc_q  <= head.exc;
                log_addr_q <= addr_q;
                log_inst_q <= head.inst;
            end
        end
    end

    assign bus.push_ready    = push_ready_q;
    assign bus.ico_data      = ico_data_q;
    assign bus.ico_exception = ico_exc_q;
    assign bus.ico_hold      = ico_hold_q;
    assign bus.log_valid     = log_valid_q;
    assign bus.log_addr      = log_addr_q;
    assign bus.log_inst      = log_inst_q;

endmodule

// File: tb/tb_guvm_icache_responder.sv
// Scoreboard bench: stimulus queues the expected delivery (word, PC, cycle);
// a negedge monitor pops and compares on every log_valid pulse.
module tb_guvm_icache_responder;
    import guvm_resp_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        exc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    logic [31:0] w[9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    guvm_icache_responder_if #(.DATA_W(32), .ADDR_W(32), .WAIT_W(4)) bus();

    guvm_icache_responder #(.DEPTH(8), .DATA_W(32), .ADDR_W(32), .WAIT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic [31:0] addr, input logic [31:0] inst,
                               input logic exc, input int dcyc);
        exp_t e;
        e.addr = addr; e.inst = inst; e.exc = exc; e.cyc = cyc + dcyc;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] inst, input logic exc);
        chk("push_ready_before_push", 64'(bus.push_ready), 64'(1));
        bus.push_valid = 1'b1;
        bus.push_inst  = inst;
        bus.push_exc   = exc;
        step();
        bus.push_valid = 1'b0;
        bus.push_exc   = 1'b0;
    endtask

    // Issue one fetch request for a single cycle.
    task automatic fetch_once(input logic [31:0] addr, input logic [3:0] ws);
        bus.fetch_req   = 1'b1;
        bus.fetch_addr  = addr;
        bus.wait_states = ws;
        step();
        bus.fetch_req   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("hold_only_in_delivery", 64'(bus.ico_hold), 64'(!bus.log_valid));
            if (bus.log_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_log_valid", 64'(bus.log_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("log_addr", 64'(bus.log_addr), 64'(e.addr));
                    chk("log_inst", 64'(bus.log_inst), 64'(e.inst));
                    chk("ico_data", 64'(bus.ico_data), 64'(e.inst));
                    chk("ico_exception", 64'(bus.ico_exception), 64'(e.exc));
                    chk("delivery_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        bus.wait_states = '0;
        bus.push_valid  = 1'b0;
        bus.push_inst   = '0;
        bus.push_exc    = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_flush = 1'b0;

        // Reset held for two cycles.
        step(2);
        chk("rst_hold", 64'(bus.ico_hold), 64'(1));
        chk("rst_ico_data", 64'(bus.ico_data), 64'h0100_0000);
        chk("rst_ico_exc", 64'(bus.ico_exception), 64'(0));
        chk("rst_push_ready", 64'(bus.push_ready), 64'(0));
        chk("rst_log_valid", 64'(bus.log_valid), 64'(0));
        chk("rst_log_addr", 64'(bus.log_addr), 64'(0));
        rst = 1'b0;
        step();
        chk("push_ready_after_rst", 64'(bus.push_ready), 64'(1));

        // Minimum latency: wait_states=0.
        push_word(32'h8E00_C002, 1'b0);
        expect_word(32'h4000_0000, 32'h8E00_C002, 1'b0, 2);
        fetch_once(32'h4000_0000, 4'd0);
        step(4);

        // wait_states=3, fetch_req held high for three back-to-back fetches.
        push_word(32'h00A0_0093, 1'b0);
        push_word(32'h0000_0013, 1'b1);
        push_word(32'h0010_8113, 1'b0);
        bus.wait_states = 4'd3;
        bus.fetch_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = 32'h0000_1000 + 32'(4 * i);
            if (i == 0) expect_word(bus.fetch_addr, 32'h00A0_0093, 1'b0, 5);
            if (i == 1) expect_word(bus.fetch_addr, 32'h0000_0013, 1'b1, 5);
            if (i == 2) expect_word(bus.fetch_addr, 32'h0010_8113, 1'b0, 5);
            step(5);
        end
        bus.fetch_req = 1'b0;
        step(3);

        // Starved fetch: word arrives ten cycles later.
        fetch_once(32'h0000_2000, 4'd0);
        step(9);
        chk("starve_hold", 64'(bus.ico_hold), 64'(1));
        expect_word(32'h0000_2000, 32'hABCD_0001, 1'b0, 2);
        push_word(32'hABCD_0001, 1'b0);
        step(4);

        // Fill to full; ninth push must be dropped.
        for (int i = 0; i < 9; i++) w[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) push_word(w[i], 1'b0);
        chk("full_push_ready", 64'(bus.push_ready), 64'(0));
        bus.push_valid = 1'b1;
        bus.push_inst  = 32'hDEAD_BEEF;
        step();
        bus.push_valid = 1'b0;
        expect_word(32'h0000_3000, w[0], 1'b0, 2);
        fetch_once(32'h0000_3000, 4'd0);
        chk("push_ready_before_pop", 64'(bus.push_ready), 64'(0));
        step();
        chk("push_ready_after_pop", 64'(bus.push_ready), 64'(1));
        push_word(w[8], 1'b0);
        chk("refull_push_ready", 64'(bus.push_ready), 64'(0));
        bus.wait_states = 4'd0;
        bus.fetch_req   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.fetch_addr = 32'h0000_3100 + 32'(4 * i);
            expect_word(bus.fetch_addr, w[i+1], 1'b0, 2);
            step(2);
        end
        bus.fetch_req = 1'b0;
        step(3);

        // Flush during WAIT drops the fetch but keeps the FIFO head.
        push_word(32'hCAFE_0001, 1'b0);
        push_word(32'hCAFE_0002, 1'b1);
        fetch_once(32'h0000_4000, 4'd5);
        step(2);
        bus.fetch_flush = 1'b1;
        step();
        bus.fetch_flush = 1'b0;
        step(10);
        chk("flush_push_ready", 64'(bus.push_ready), 64'(1));
        expect_word(32'h0000_4004, 32'hCAFE_0001, 1'b0, 3);
        fetch_once(32'h0000_4004, 4'd1);
        step(4);
        expect_word(32'h0000_4008, 32'hCAFE_0002, 1'b1, 4);
        fetch_once(32'h0000_4008, 4'd2);
        step(5);

        // Reset mid-fetch discards the fetch and empties the FIFO.
        push_word(32'h5555_0001, 1'b0);
        fetch_once(32'h0000_5000, 4'd4);
        step();
        rst = 1'b1;
        step();
        chk("midrst_hold", 64'(bus.ico_hold), 64'(1));
        chk("midrst_ico_data", 64'(bus.ico_data), 64'h0100_0000);
        chk("midrst_push_ready", 64'(bus.push_ready), 64'(0));
        rst = 1'b0;
        step(6);
        fetch_once(32'h0000_6000, 4'd0);
        step(3);
        expect_word(32'h0000_6000, 32'h5555_0002, 1'b0, 2);
        push_word(32'h5555_0002, 1'b0);

        begin : drain
            int budget = 100;
            while (exp_q.size() != 0 && budget > 0) begin
                step();
                budget--;
            end
            if (exp_q.size() != 0)
                chk("drain_timeout_pending", 64'(exp_q.size()), 64'(0));
        end
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
